pico_s2p_decoder: RTL

PICO_S2P_DECODER -- requirements
Module: pico_s2p_decoder

---
 rtl/pico_s2p_decoder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pico_s2p_decoder.sv
// Serial-to-parallel register decoder: receives {rw, addr[6:0]} (+ data byte on writes) MSB first
// on pico while csb is low, updates the register bank or readback mux address, and pulses status.
module pico_s2p_decoder #(
  parameter int NUM_REGS = 56
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic                  csb,
  input  logic                  pico,
  output logic [7:0]            mux_control_signal,
  output logic                  load,
  output logic [NUM_REGS*8-1:0] reg_data,
  output logic                  wr_strobe,
  output logic                  addr_err
);

  localparam logic [7:0] LP_MAX_ADDR = 8'(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_HOLD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [7:0]  r_shift;
  logic [6:0]  r_addr;
  logic        r_csb_q;
  logic [7:0]  w_byte;
  logic        w_last;
  logic        w_addr_ok;
  logic        w_start;
  logic        w_sample;
  logic        w_do_load;
  logic        w_do_err;
  logic        w_do_write;

  assign w_byte    = {r_shift[6:0], pico};
  assign w_last    = (r_cnt == 3'd7);
  assign w_addr_ok = (w_byte[6:0] != 7'd0) && ({1'b0, w_byte[6:0]} <= LP_MAX_ADDR);

  // Frames start only on a csb falling edge, so a reset with csb held low never resumes a frame.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_sample    = 1'b0;
    w_do_load   = 1'b0;
    w_do_err    = 1'b0;
    w_do_write  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!csb && r_csb_q) begin
          w_state_nxt = S_ADDR;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ADDR: begin
        if (csb) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_sample = 1'b1;
          if (!w_last) begin
            w_state_nxt = S_ADDR;
          end else if (!w_addr_ok) begin
            w_state_nxt = S_HOLD;
            w_do_err    = 1'b1;
          end else if (w_byte[7]) begin
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_HOLD;
            w_do_load   = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (csb) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_sample = 1'b1;
          if (w_last) begin
            w_state_nxt = S_HOLD;
            w_do_write  = 1'b1;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      end
      S_HOLD: begin
        if (csb) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The first bit is captured on the IDLE->ADDR edge, hence the counter restarts at 1.
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_cnt              <= 3'd0;
      r_shift            <= 8'd0;
      r_addr             <= 7'd0;
      r_csb_q            <= 1'b0;
      mux_control_signal <= 8'd0;
      load               <= 1'b0;
      wr_strobe          <= 1'b0;
      addr_err           <= 1'b0;
    end else begin
      r_csb_q   <= csb;
      load      <= w_do_load;
      wr_strobe <= w_do_write;
      addr_err  <= w_do_err;
      if (w_start) begin
        r_cnt   <= 3'd1;
        r_shift <= w_byte;
      end else if (w_sample) begin
        r_cnt   <= r_cnt + 3'd1;
        r_shift <= w_byte;
      end else begin
        r_cnt   <= 3'd0;
      end
      if (r_state == S_ADDR && w_sample && w_last) begin
        r_addr <= w_byte[6:0];
      end
      if (w_do_load) begin
        mux_control_signal <= {1'b0, w_byte[6:0]};
      end
    end
  end

  // Register k lives at address k+1.
  always_ff @(posedge sclk) begin
    if (rst) begin
      reg_data <= '0;
    end else if (w_do_write) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (r_addr == 7'(k + 1)) begin
          reg_data[8*k +: 8] <= w_byte;
        end
      end
    end
  end

endmodule
